// File: rtl/shiftreg_ser_ctrl.sv
// ============================================================================
// Module   : shiftreg_ser_ctrl
// Purpose  : Sequences a 4-op shift register to serialize one parallel word at
//            a time over valid/ready, with backpressure on the serial side.
//            Optional even-parity trailer beat: SHIFTREG_SER_CTRL_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shiftreg_ser_ctrl #(
  parameter int   N    = 4,
  parameter logic FILL = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         msb_first,
  input  logic         out_ready,
  output logic         ser_bit,
  output logic         ser_valid,
  output logic         ser_last,
  output logic         busy,
  output logic         done,
  output logic [1:0]   sr_OP,
  output logic [N-1:0] sr_d,
  output logic         sr_shift_in,
  input  logic         sr_shift_out_left,
  input  logic         sr_shift_out_right
);

  localparam int CW = $clog2(N + 1);
`ifdef SHIFTREG_SER_CTRL_PARITY_EN
  localparam int BEATS = N + 1;
`else
  localparam int BEATS = N;
`endif
  localparam logic [CW-1:0] c_LAST    = CW'(BEATS - 1);
  localparam logic [1:0]    c_OP_HOLD = 2'b00;
  localparam logic [1:0]    c_OP_SHL  = 2'b01;
  localparam logic [1:0]    c_OP_SHR  = 2'b10;
  localparam logic [1:0]    c_OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_dir;
  logic [N-1:0]  r_word;
  logic          w_data_beat;
  logic          w_accept;
  logic          w_beat_ok;

`ifdef SHIFTREG_SER_CTRL_PARITY_EN
  logic r_par;

  // The trailer beat sits at cnt == N; the register is idle during it.
  assign w_data_beat = (r_cnt != CW'(N));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ^in_data;
    end
  end
`else
  assign w_data_beat = 1'b1;
`endif

  assign w_accept  = (r_state == S_IDLE) && in_valid && !reset;
  assign w_beat_ok = (r_state == S_SHIFT) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_word <= in_data;
        r_dir  <= msb_first;
      end
      if (r_state == S_LOAD) begin
        r_cnt <= '0;
      end else if (w_beat_ok) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    ser_valid   = 1'b0;
    ser_last    = 1'b0;
    ser_bit     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    sr_OP       = c_OP_HOLD;
    sr_d        = r_word;
    sr_shift_in = FILL;
    // Reset overrides everything so nothing is accepted or signalled.
    if (!reset) begin
      case (r_state)
        S_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            w_state_nxt = S_LOAD;
          end
        end
        S_LOAD: begin
          busy        = 1'b1;
          sr_OP       = c_OP_LOAD;
          w_state_nxt = S_SHIFT;
        end
        S_SHIFT: begin
          busy      = 1'b1;
          ser_valid = 1'b1;
          ser_last  = (r_cnt == c_LAST);
          ser_bit   = r_dir ? sr_shift_out_left : sr_shift_out_right;
`ifdef SHIFTREG_SER_CTRL_PARITY_EN
          if (!w_data_beat) begin
            ser_bit = r_par;
          end
`endif
          if (out_ready) begin
            if (w_data_beat) begin
              sr_OP = r_dir ? c_OP_SHL : c_OP_SHR;
            end
            if (r_cnt == c_LAST) begin
              w_state_nxt = S_DONE;
            end
          end
        end
        S_DONE: begin
          busy        = 1'b1;
          done        = 1'b1;
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shiftreg_ser_ctrl.sv
// ============================================================================
// Module   : tb_shiftreg_ser_ctrl
// Purpose  : Self-checking bench for shiftreg_ser_ctrl with a behavioural
//            shift register and a queue-based stream model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_shiftreg_ser_ctrl;

  localparam int N = 4;
`ifdef SHIFTREG_SER_CTRL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int LAT    = N + 2 + PAR;
  localparam int PERIOD = N + 3 + PAR;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         msb_first;
  logic         out_ready;
  logic         ser_bit, ser_valid, ser_last, busy, done;
  logic [1:0]   sr_OP;
  logic [N-1:0] sr_d;
  logic         sr_shift_in;
  logic [N-1:0] q;

  shiftreg_ser_ctrl #(.N(N), .FILL(1'b0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .msb_first(msb_first), .out_ready(out_ready),
    .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_last(ser_last),
    .busy(busy), .done(done), .sr_OP(sr_OP), .sr_d(sr_d),
    .sr_shift_in(sr_shift_in), .sr_shift_out_left(q[N-1]),
    .sr_shift_out_right(q[0])
  );

  always #5 clk = ~clk;

  // Companion 4-op shift register, enable tied high, no reset.
  always @(posedge clk) begin
    case (sr_OP)
      2'b01:   q <= {q[N-2:0], sr_shift_in};
      2'b10:   q <= {sr_shift_in, q[N-1:1]};
      2'b11:   q <= sr_d;
      default: q <= q;
    endcase
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Stream model: pending beats of the current word, in transmission order.
  logic         exp_bit[$];
  logic         exp_data[$];
  logic         m_load = 1'b0;
  logic         m_done = 1'b0;
  logic         m_dir  = 1'b0;
  logic [N-1:0] m_word = '0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           done_cyc = 0;
  int           done_cnt = 0;
  logic         log_q[$];

  always @(posedge clk) begin
    logic idle;
    cyc++;
    if (reset) begin
      exp_bit.delete();
      exp_data.delete();
      m_load = 1'b0;
      m_done = 1'b0;
    end else begin
      idle = !m_load && !m_done && (exp_bit.size() == 0);
      if (m_done) m_done = 1'b0;
      else if (m_load) m_load = 1'b0;
      else if (exp_bit.size() > 0 && out_ready) begin
        void'(exp_bit.pop_front());
        void'(exp_data.pop_front());
        if (exp_bit.size() == 0) m_done = 1'b1;
      end
      if (idle && in_valid) begin
        m_load = 1'b1;
        m_dir  = msb_first;
        m_word = in_data;
        for (int i = 0; i < N; i++) begin
          exp_bit.push_back(msb_first ? in_data[N-1-i] : in_data[i]);
          exp_data.push_back(1'b1);
        end
        if (PAR == 1) begin
          exp_bit.push_back(^in_data);
          exp_data.push_back(1'b0);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic idle, ev;
    logic [1:0] eop;
    if (reset) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_ser_valid", ser_valid, 0);
      chk("rst_ser_last", ser_last, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sr_OP", sr_OP, 0);
    end else begin
      idle = !m_load && !m_done && (exp_bit.size() == 0);
      ev   = !m_load && (exp_bit.size() > 0);
      chk("in_ready", in_ready, idle);
      chk("busy", busy, !idle);
      chk("done", done, m_done);
      chk("ser_valid", ser_valid, ev);
      chk("ser_last", ser_last, ev && (exp_bit.size() == 1));
      eop = 2'b00;
      if (m_load) eop = 2'b11;
      else if (ev && out_ready && exp_data[0]) eop = m_dir ? 2'b01 : 2'b10;
      chk("sr_OP", sr_OP, eop);
      if (m_load) chk("sr_d", sr_d, m_word);
      if (ev) begin
        chk("ser_bit", ser_bit, exp_bit[0]);
        if (out_ready) log_q.push_back(ser_bit);
      end
      if (idle && in_valid) acc_cyc = cyc;
      if (done) begin
        done_cyc = cyc;
        done_cnt++;
      end
    end
  end

  function automatic logic [31:0] log_val();
    logic [31:0] v = 0;
    foreach (log_q[i]) v = (v << 1) | 32'(log_q[i]);
    return v;
  endfunction

  // Picks the literal for the active build and compares the logged stream.
  task automatic chk_stream(input string nm, input logic [31:0] e_plain, input logic [31:0] e_par, input int beats);
    chk({nm, "_stream"}, log_val(), (PAR == 1) ? e_par : e_plain);
    chk({nm, "_beats"}, log_q.size(), beats + PAR * (beats / N));
    log_q.delete();
  endtask

  task automatic accept(input logic [N-1:0] w, input logic msb);
    bit ok = 0;
    in_data = w; msb_first = msb; in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
    end
    if (!ok) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int accs[4];
    int d0;
    bit ok;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; msb_first = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    log_q.delete();

    // MSB-first, no stall
    accept(4'b1010, 1'b1);
    wait_done();
    chk_stream("t1", 32'b1010, 32'b10100, 4);
    chk("t1_latency", done_cyc - acc_cyc, LAT);

    // LSB-first
    accept(4'b1010, 1'b0);
    wait_done();
    chk_stream("t2a", 32'b0101, 32'b01010, 4);
    accept(4'b1111, 1'b0);
    wait_done();
    chk_stream("t2b", 32'b1111, 32'b11110, 4);

    // Backpressure: three stall cycles on beat 2
    accept(4'b1100, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_done();
    chk_stream("t3", 32'b1100, 32'b11000, 4);
    chk("t3_latency", done_cyc - acc_cyc, LAT + 3);

    // in_valid held high with alternating words
    in_valid = 1'b1; msb_first = 1'b1;
    for (int w = 0; w < 4; w++) begin
      in_data = (w % 2 == 1) ? 4'b1001 : 4'b0110;
      ok = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("t4_accept_timeout", 0, 1);
      accs[w] = cyc;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done();
    for (int w = 1; w < 4; w++) chk("t4_period", accs[w] - accs[w-1], PERIOD);
    chk_stream("t4", 32'b0110_1001_0110_1001, 32'b01100_10010_01100_10010, 16);

    // Reset during beat 3
    accept(4'b1010, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("t5_ser_valid", ser_valid, 0);
    chk("t5_busy", busy, 0);
    repeat (4) @(negedge clk);
    chk("t5_no_done", done_cnt, d0);
    chk("t5_partial", log_val(), 32'b10);
    log_q.delete();
    @(posedge clk); #1;
    accept(4'b0011, 1'b1);
    wait_done();
    chk_stream("t5", 32'b0011, 32'b00110, 4);

`ifdef SHIFTREG_SER_CTRL_PARITY_EN
    accept(4'b1011, 1'b1);
    wait_done();
    chk_stream("p1", 32'b1011, 32'b10111, 4);
    accept(4'b1001, 1'b1);
    wait_done();
    chk_stream("p2", 32'b1001, 32'b10010, 4);
    chk("p2_latency", done_cyc - acc_cyc, N + 3);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
